// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

    localparam int DEFAULT_N = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit counter width; kept at least 1 so a 2-bit adder still has a counter bit.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/full_adder_1bit.sv
// Single-bit full adder cell: the per-bit sum/carry stage of the serial adder.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_4bit.sv
// Bit-serial adder: latches A/B/Cin, adds one bit per cycle LSB first through a
// single full adder, then holds S/Cout until the consumer takes the result.
module serial_adder_4bit
    import serial_adder_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] S,
    output logic         Cout
);

    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    state_t        state_reg;
    state_t        state_next;
    logic [CW-1:0] cnt_reg;
    logic [N-1:0]  a_sh_reg;
    logic [N-1:0]  b_sh_reg;
    logic [N-1:0]  sum_sh_reg;
    logic          carry_reg;
    logic          fa_s;
    logic          fa_cout;

    full_adder_1bit u_fa (
        .a    (a_sh_reg[0]),
        .b    (b_sh_reg[0]),
        .cin  (carry_reg),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_reg == LAST_BIT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Sum bits enter at the MSB so after N shifts bit 0 sits at the LSB;
    // the final carry stays in carry_reg and doubles as Cout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            sum_sh_reg <= '0;
            carry_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_reg  <= A;
                        b_sh_reg  <= B;
                        carry_reg <= Cin;
                        cnt_reg   <= '0;
                    end
                end
                SHIFT: begin
                    a_sh_reg   <= a_sh_reg >> 1;
                    b_sh_reg   <= b_sh_reg >> 1;
                    carry_reg  <= fa_cout;
                    sum_sh_reg <= {fa_s, sum_sh_reg[N-1:1]};
                    if (cnt_reg != LAST_BIT) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign S    = sum_sh_reg;
    assign Cout = carry_reg;

endmodule

// File: tb/tb_serial_adder_4bit.sv
// Directed bench for serial_adder_4bit: vector table, corner-case sequences and a full sweep.
module tb_serial_adder_4bit;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
    logic         Cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] S;
    logic         Cout;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] exp_s;
        logic       exp_cout;
    } vec_t;

    vec_t vecs [10];

    serial_adder_4bit #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Cout      (Cout)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // One complete transaction with out_ready high; checks latency, result and return to IDLE.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic c,
                         input logic [3:0] exp_s, input logic exp_cout,
                         input string tag, input bit verbose);
        int lat;
        @(negedge clk);
        lat = 0;
        while (!in_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        A = a; B = b; Cin = c; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        A = ~a; B = ~b; Cin = ~c;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(N));
        check({tag, "_S"}, 32'(S), 32'(exp_s));
        check({tag, "_Cout"}, 32'(Cout), 32'(exp_cout));
        if (verbose)
            $display("op %s: A=%0d B=%0d Cin=%0d -> S=%0d Cout=%0d lat=%0d", tag, a, b, c, S, Cout, lat);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_S_retained"}, 32'(S), 32'(exp_s));
    endtask

    initial begin
        int lat;
        int pulses;
        logic [4:0] total;

        vecs[0] = '{4'd5,  4'd3,  1'b0, 4'd8,  1'b0};
        vecs[1] = '{4'd15, 4'd1,  1'b0, 4'd0,  1'b1};
        vecs[2] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1};
        vecs[3] = '{4'd0,  4'd0,  1'b0, 4'd0,  1'b0};
        vecs[4] = '{4'd0,  4'd0,  1'b1, 4'd1,  1'b0};
        vecs[5] = '{4'd10, 4'd5,  1'b0, 4'd15, 1'b0};
        vecs[6] = '{4'd7,  4'd9,  1'b1, 4'd1,  1'b1};
        vecs[7] = '{4'd8,  4'd8,  1'b0, 4'd0,  1'b1};
        vecs[8] = '{4'd12, 4'd3,  1'b1, 4'd0,  1'b1};
        vecs[9] = '{4'd6,  4'd6,  1'b1, 4'd13, 1'b0};

        // Reset state, with out_ready high to show it has no effect outside DONE.
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_S", 32'(S), 32'd0);
        check("rst_Cout", 32'(Cout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_s, vecs[i].exp_cout,
                  $sformatf("vec%0d", i), 1'b1);
        end

        // Backpressure: hold out_ready low in DONE while in_valid pokes new operands.
        @(negedge clk);
        A = 4'd11; B = 4'd2; Cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("bp_latency", 32'(lat), 32'(N));
        for (int k = 0; k < 5; k++) begin
            A = 4'(k + 1); B = 4'd7; in_valid = 1'b1;
            @(negedge clk);
            check($sformatf("bp_hold%0d_out_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("bp_hold%0d_S", k), 32'(S), 32'd13);
            check($sformatf("bp_hold%0d_Cout", k), 32'(Cout), 32'd0);
            check($sformatf("bp_hold%0d_in_ready", k), 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_S", 32'(S), 32'd13);
        $display("op backpressure: A=11 B=2 Cin=0 held 5 cycles -> S=%0d Cout=%0d", S, Cout);

        // in_valid held high with changing operands during SHIFT.
        @(negedge clk);
        A = 4'd3; B = 4'd4; Cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("hold_in_ready_shift", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            A = A + 4'd5; B = B ^ 4'hA; Cin = ~Cin;
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check("hold_latency", 32'(lat), 32'(N));
        check("hold_S", 32'(S), 32'd7);
        check("hold_Cout", 32'(Cout), 32'd0);
        $display("op hold_in_valid: A=3 B=4 Cin=0 -> S=%0d Cout=%0d lat=%0d", S, Cout, lat);
        @(posedge clk);
        @(negedge clk);
        check("hold_out_valid_drop", 32'(out_valid), 32'd0);

        // Reset pulse while bit 2 is being processed aborts the operation.
        @(negedge clk);
        A = 4'd15; B = 4'd15; Cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_S", 32'(S), 32'd0);
        check("abort_Cout", 32'(Cout), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("abort_no_out_valid", 32'(pulses), 32'd0);
        $display("op abort: reset during bit 2, out_valid pulses=%0d", pulses);
        do_op(4'd9, 4'd6, 1'b1, 4'd0, 1'b1, "after_abort", 1'b1);

        // Exhaustive sweep against a plain 5-bit sum.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    total = 5'(a) + 5'(b) + 5'(c);
                    do_op(4'(a), 4'(b), 1'(c), total[3:0], total[4],
                          $sformatf("sweep_%0d_%0d_%0d", a, b, c), 1'b0);
                end
            end
        end
        $display("op sweep: 512 operand sets applied");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
